// File: rtl/mips_mem_arbiter_pkg.sv
// Shared constants for the host/MIPS memory arbiter: FSM encoding,
// requester IDs and default bus widths.
package mips_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_MIPS = 1'b1;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Two-requester (host / MIPS) arbiter in front of a single-port external memory
// with one-cycle read latency.
//
// state  | meaning
// IDLE   | wait for an eligible request, pick winner (round-robin on tie), latch it
// ACCESS | drive memory for one cycle, pulse winner's ack
// RESP   | read only: return memory data to winner, pulse its rvalid
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic [3:0]        h_wstrb,
    output logic              h_ack,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,

    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic [3:0]        m_wstrb,
    output logic              m_ack,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,

    input  logic              mips_hold,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [15:0]       conflict_cnt
);

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_h_rdata;
    logic [DATA_W-1:0] r_m_rdata;
    logic [15:0]       r_conflict_cnt;

    logic w_h_elig;
    logic w_m_elig;
    logic w_tie;
    logic w_winner;
    logic w_access;
    logic w_resp;

    assign w_h_elig = h_req;
    assign w_m_elig = m_req & ~mips_hold;
    assign w_tie    = w_h_elig & w_m_elig;
    assign w_winner = w_tie    ? ~r_last_grant :
                      w_h_elig ? REQ_HOST      : REQ_MIPS;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state        <= ST_IDLE;
            r_grant        <= REQ_MIPS;
            r_last_grant   <= REQ_MIPS;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= 4'b0000;
            r_h_rdata      <= '0;
            r_m_rdata      <= '0;
            r_conflict_cnt <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tie && (r_conflict_cnt != 16'hFFFF)) begin
                        r_conflict_cnt <= r_conflict_cnt + 16'd1;
                    end
                    if (w_h_elig || w_m_elig) begin
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_we         <= (w_winner == REQ_HOST) ? h_we    : m_we;
                        r_addr       <= (w_winner == REQ_HOST) ? h_addr  : m_addr;
                        r_wdata      <= (w_winner == REQ_HOST) ? h_wdata : m_wdata;
                        r_wstrb      <= (w_winner == REQ_HOST) ? h_wstrb : m_wstrb;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_state <= r_we ? ST_IDLE : ST_RESP;
                end
                ST_RESP: begin
                    if (r_grant == REQ_HOST) begin
                        r_h_rdata <= mem_rdata;
                    end else begin
                        r_m_rdata <= mem_rdata;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are qualified by reset so an access caught by reset never pulses.
    assign w_access = S_AXI_ARESETN && (r_state == ST_ACCESS);
    assign w_resp   = S_AXI_ARESETN && (r_state == ST_RESP);

    assign mem_en    = w_access;
    assign mem_we    = (w_access && r_we) ? r_wstrb : 4'b0000;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign h_ack    = w_access && (r_grant == REQ_HOST);
    assign m_ack    = w_access && (r_grant == REQ_MIPS);
    assign h_rvalid = w_resp && (r_grant == REQ_HOST);
    assign m_rvalid = w_resp && (r_grant == REQ_MIPS);

    // Read data is forwarded during the rvalid cycle, then held from the register.
    assign h_rdata = h_rvalid ? mem_rdata : r_h_rdata;
    assign m_rdata = m_rvalid ? mem_rdata : r_m_rdata;

    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter with a behavioural one-cycle memory.
module tb_mips_mem_arbiter;
    import mips_mem_arbiter_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

    typedef struct {
        logic          who;
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    strb;
        logic [DW-1:0] wdata;
    } mem_op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          h_req, h_we, h_ack, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic [3:0]    h_wstrb;
    logic          m_req, m_we, m_ack, m_rvalid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic          mips_hold;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   conflict_cnt;

    mem_op_t       q_mem[$];
    logic [DW-1:0] q_hrd[$];
    logic [DW-1:0] q_mrd[$];
    int            en_hist[$];
    mem_op_t       mon_e;
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            mon_on = 1'b0;
    logic          exp_last;
    int            exp_cnt;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
        .h_ack(h_ack), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .mips_hold(mips_hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (a == 11'h010) ? 32'h1234ABCD : (32'hC0DE0000 | {21'b0, a});
    endfunction

    logic [DW-1:0] mem [0:2047];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(11'(i));
            mem_rdata <= '0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (mem_en) begin
                en_hist.push_back(cyc);
                if (q_mem.size() == 0) begin
                    check_eq("mem_en_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    mon_e = q_mem.pop_front();
                    check_eq("h_ack", 32'(h_ack), 32'(mon_e.who == REQ_HOST));
                    check_eq("m_ack", 32'(m_ack), 32'(mon_e.who == REQ_MIPS));
                    check_eq("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check_eq("mem_we", 32'(mem_we), 32'(mon_e.we ? mon_e.strb : 4'b0000));
                    if (mon_e.we) check_eq("mem_wdata", mem_wdata, mon_e.wdata);
                end
            end else begin
                check_eq("idle_ack_we", 32'({h_ack, m_ack, mem_we}), 32'd0);
            end
            if (h_rvalid) begin
                if (q_hrd.size() == 0) check_eq("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
                else check_eq("h_rdata", h_rdata, q_hrd.pop_front());
            end
            if (m_rvalid) begin
                if (q_mrd.size() == 0) check_eq("m_rvalid_unexpected", 32'(m_rvalid), 32'd0);
                else check_eq("m_rdata", m_rdata, q_mrd.pop_front());
            end
        end
    end

    task automatic push_op(input logic who, input logic [AW-1:0] a, input logic we,
                           input logic [3:0] s, input logic [DW-1:0] d);
        mem_op_t e;
        e.who = who; e.addr = a; e.we = we; e.strb = s; e.wdata = d;
        q_mem.push_back(e);
        exp_last = who;
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input bit keep);
        int n;
        h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d; h_wstrb = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!h_ack && n < 64);
        if (!h_ack) check_eq("h_ack_timeout", 32'(h_ack), 32'd1);
        @(posedge clk); #1;
        if (!keep) h_req = 1'b0;
    endtask

    task automatic mips_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input bit keep);
        int n;
        m_req = 1'b1; m_we = we; m_addr = a; m_wdata = d; m_wstrb = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_ack && n < 64);
        if (!m_ack) check_eq("m_ack_timeout", 32'(m_ack), 32'd1);
        @(posedge clk); #1;
        if (!keep) m_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q_mem.size() + q_hrd.size() + q_mrd.size()) != 0 && n < 64) begin
            @(negedge clk); n++;
        end
        check_eq(tag, 32'(q_mem.size() + q_hrd.size() + q_mrd.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string p);
        check_eq({p, "_h_ack"},    32'(h_ack), 32'd0);
        check_eq({p, "_h_rvalid"}, 32'(h_rvalid), 32'd0);
        check_eq({p, "_m_ack"},    32'(m_ack), 32'd0);
        check_eq({p, "_m_rvalid"}, 32'(m_rvalid), 32'd0);
        check_eq({p, "_mem_en"},   32'(mem_en), 32'd0);
        check_eq({p, "_mem_we"},   32'(mem_we), 32'd0);
        check_eq({p, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({p, "_mem_wdata"}, mem_wdata, 32'd0);
        check_eq({p, "_h_rdata"},  h_rdata, 32'd0);
        check_eq({p, "_m_rdata"},  m_rdata, 32'd0);
        check_eq({p, "_cnt"},      32'(conflict_cnt), 32'd0);
    endtask

    // Both requesters issue n writes back to back; the bench predicts strict alternation.
    task automatic tie_run(input int n, input int hbase, input int mbase);
        logic first;
        first = ~exp_last;
        for (int i = 0; i < n; i++) begin
            if (first == REQ_HOST) begin
                push_op(REQ_HOST, 11'(hbase + i), 1'b1, 4'hF, 32'hA000_0000 + 32'(i));
                push_op(REQ_MIPS, 11'(mbase + i), 1'b1, 4'hF, 32'hB000_0000 + 32'(i));
            end else begin
                push_op(REQ_MIPS, 11'(mbase + i), 1'b1, 4'hF, 32'hB000_0000 + 32'(i));
                push_op(REQ_HOST, 11'(hbase + i), 1'b1, 4'hF, 32'hA000_0000 + 32'(i));
            end
        end
        exp_cnt = exp_cnt + 2 * n - 1;
        if (exp_cnt > 32'hFFFF) exp_cnt = 32'hFFFF;
        fork
            begin
                for (int i = 0; i < n; i++)
                    host_op(1'b1, 11'(hbase + i), 32'hA000_0000 + 32'(i), 4'hF, i < n - 1);
            end
            begin
                for (int j = 0; j < n; j++)
                    mips_op(1'b1, 11'(mbase + j), 32'hB000_0000 + 32'(j), 4'hF, j < n - 1);
            end
        join
    endtask

    initial begin
        int n;
        rst_n = 1'b0; mips_hold = 1'b0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_wstrb = '0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        exp_last = REQ_MIPS; exp_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1; mon_on = 1'b1;

        // simultaneous writes right after reset: host first, MIPS two cycles later
        en_hist.delete();
        push_op(REQ_HOST, 11'h001, 1'b1, 4'hF, 32'h1111_1111);
        push_op(REQ_MIPS, 11'h002, 1'b1, 4'hF, 32'h2222_2222);
        exp_cnt = 1;
        fork
            host_op(1'b1, 11'h001, 32'h1111_1111, 4'hF, 1'b0);
            mips_op(1'b1, 11'h002, 32'h2222_2222, 4'hF, 1'b0);
        join
        wait_drain("drain_tie");
        check_eq("tie_en_count", 32'(en_hist.size()), 32'd2);
        if (en_hist.size() == 2) check_eq("tie_en_gap", 32'(en_hist[1] - en_hist[0]), 32'd2);
        check_eq("tie_cnt", 32'(conflict_cnt), 32'(exp_cnt));
        push_op(REQ_MIPS, 11'h001, 1'b0, 4'h0, 32'h0);
        q_mrd.push_back(32'h1111_1111);
        mips_op(1'b0, 11'h001, 32'h0, 4'h0, 1'b0);
        wait_drain("drain_mrd");

        // host read latency
        push_op(REQ_HOST, 11'h010, 1'b0, 4'h0, 32'h0);
        q_hrd.push_back(32'h1234ABCD);
        h_req = 1'b1; h_we = 1'b0; h_addr = 11'h010;
        @(negedge clk);
        check_eq("lat_n_ack", 32'(h_ack), 32'd0);
        @(negedge clk);
        check_eq("lat_n1_ack", 32'(h_ack), 32'd1);
        check_eq("lat_n1_rvalid", 32'(h_rvalid), 32'd0);
        @(posedge clk); #1;
        h_req = 1'b0;
        @(negedge clk);
        check_eq("lat_n2_rvalid", 32'(h_rvalid), 32'd1);
        check_eq("lat_n2_rdata", h_rdata, 32'h1234ABCD);
        check_eq("lat_n2_m_rvalid", 32'(m_rvalid), 32'd0);
        @(negedge clk);
        check_eq("lat_n3_rvalid", 32'(h_rvalid), 32'd0);
        check_eq("lat_hold_rdata", h_rdata, 32'h1234ABCD);
        wait_drain("drain_hrd");

        // partial-byte write, then read back the merged word
        push_op(REQ_HOST, 11'h020, 1'b1, 4'b0101, 32'hDEADBEEF);
        host_op(1'b1, 11'h020, 32'hDEADBEEF, 4'b0101, 1'b0);
        wait_drain("drain_strb");
        push_op(REQ_HOST, 11'h020, 1'b0, 4'h0, 32'h0);
        q_hrd.push_back((pat(11'h020) & 32'hFF00FF00) | (32'hDEADBEEF & 32'h00FF00FF));
        host_op(1'b0, 11'h020, 32'h0, 4'h0, 1'b0);
        wait_drain("drain_strb_rd");

        // MIPS held off, then released; hold re-asserted mid-access must not abort it
        m_req = 1'b1; m_we = 1'b0; m_addr = 11'h030; mips_hold = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_eq("hold_m_ack", 32'(m_ack), 32'd0);
            check_eq("hold_mem_en", 32'(mem_en), 32'd0);
        end
        @(posedge clk); #1;
        mips_hold = 1'b0;
        push_op(REQ_MIPS, 11'h030, 1'b0, 4'h0, 32'h0);
        q_mrd.push_back(pat(11'h030));
        n = 0;
        do begin @(negedge clk); n++; end while (!m_ack && n < 2);
        check_eq("unhold_ack", 32'(m_ack), 32'd1);
        mips_hold = 1'b1;
        @(posedge clk); #1;
        m_req = 1'b0;
        wait_drain("drain_hold");
        mips_hold = 1'b0;
        check_eq("single_cnt", 32'(conflict_cnt), 32'(exp_cnt));

        // reset landing in RESP of a host read
        push_op(REQ_HOST, 11'h040, 1'b0, 4'h0, 32'h0);
        h_req = 1'b1; h_we = 1'b0; h_addr = 11'h040;
        @(negedge clk);
        @(negedge clk);
        check_eq("rr_ack", 32'(h_ack), 32'd1);
        @(posedge clk); #1;
        h_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_eq("rr_rvalid_in_rst", 32'(h_rvalid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rr");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_last = REQ_MIPS; exp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rr_no_rvalid", 32'(h_rvalid), 32'd0);
        end
        check_eq("rr_q_mem_used", 32'(q_mem.size()), 32'd0);
        @(posedge clk); #1;
        push_op(REQ_HOST, 11'h050, 1'b1, 4'hF, 32'h5555_AAAA);
        host_op(1'b1, 11'h050, 32'h5555_AAAA, 4'hF, 1'b0);
        wait_drain("drain_rr");

        // continuous ties: strict alternation, exact tie count
        en_hist.delete();
        tie_run(40, 32'h100, 32'h200);
        wait_drain("drain_run1");
        check_eq("run1_cnt", 32'(conflict_cnt), 32'(exp_cnt));
        check_eq("run1_en_count", 32'(en_hist.size()), 32'd80);
        for (int i = 1; i < en_hist.size(); i++)
            check_eq("run1_gap", 32'(en_hist[i] - en_hist[i-1]), 32'd2);

        // saturation: preload the counter near the top, then keep tying
        force dut.r_conflict_cnt = 16'hFFF0;
        @(posedge clk); #1;
        release dut.r_conflict_cnt;
        @(negedge clk);
        check_eq("preload_cnt", 32'(conflict_cnt), 32'h0000FFF0);
        exp_cnt = 32'hFFF0;
        @(posedge clk); #1;
        tie_run(20, 32'h300, 32'h380);
        wait_drain("drain_run2");
        check_eq("sat_cnt", 32'(conflict_cnt), 32'(exp_cnt));
        check_eq("sat_cnt_max", 32'(conflict_cnt), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
